// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - sizing helpers and stage control type for the CSA resolve pipeline
package csa_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
    } seg_ctl_t;

    function automatic int seg_count(input int in_w, input int seg_w);
        return (in_w + seg_w - 1) / seg_w;
    endfunction

    function automatic int seg_lo(input int seg_w, input int k);
        return k * seg_w;
    endfunction

    // The top segment takes whatever bits are left over, so it may be narrower.
    function automatic int seg_width(input int in_w, input int seg_w, input int k);
        int lo;
        lo = k * seg_w;
        return ((in_w - lo) < seg_w) ? (in_w - lo) : seg_w;
    endfunction

endpackage

// File: rtl/csa_resolve_seg.sv
// rtl/csa_resolve_seg.sv - one carry-chain segment: W-bit add with carry-in, enabled register
module csa_resolve_seg
    import csa_pkg::*;
#(
    parameter int IN_W = 4,
    parameter int LO   = 0,
    parameter int W    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic            i_valid,
    input  logic [IN_W-1:0] i_lane,
    input  logic [W-1:0]    i_carry,
    input  logic            i_cin,
    output logic            o_valid,
    output logic [IN_W-1:0] o_lane,
    output logic            o_cout
);

    logic [W:0]      w_add;
    logic [IN_W-1:0] w_lane_nxt;
    seg_ctl_t        r_ctl;
    logic [IN_W-1:0] r_lane;

    assign w_add = {1'b0, i_lane[LO+W-1:LO]} + {1'b0, i_carry} + {{W{1'b0}}, i_cin};

    // The lane holds resolved bits below LO+W and raw sum bits above it.
    always_comb begin
        w_lane_nxt              = i_lane;
        w_lane_nxt[LO+W-1:LO]   = w_add[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl  <= '0;
            r_lane <= '0;
        end else if (i_en) begin
            r_ctl.valid <= i_valid;
            r_ctl.carry <= w_add[W];
            r_lane      <= w_lane_nxt;
        end
    end

    assign o_valid = r_ctl.valid;
    assign o_cout  = r_ctl.carry;
    assign o_lane  = r_lane;

endmodule

// File: rtl/csa_resolve_pipe.sv
// rtl/csa_resolve_pipe.sv - segmented carry-propagate adder resolving a CSA sum/carry pair
module csa_resolve_pipe
    import csa_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int SEG_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [IN_W-1:0] i_sum,
    input  logic [IN_W-1:0] i_carry,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [IN_W:0]   o_result
);

    localparam int NSEG = seg_count(IN_W, SEG_W);

    logic w_en;

    // Single global stall: the whole pipe advances only when the output slot frees up.
    assign w_en    = !o_valid || i_ready;
    assign o_ready = w_en;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO = seg_lo(SEG_W, k);
        localparam int W  = seg_width(IN_W, SEG_W, k);

        logic [IN_W-LO-1:0] w_car_src;
        logic [IN_W-1:0]    w_lane_in;
        logic [IN_W-1:0]    w_lane;
        logic               w_vin;
        logic               w_cin;
        logic               w_valid;
        logic               w_cout;

        if (k == 0) begin : g_head
            assign w_car_src = i_carry;
            assign w_lane_in = i_sum;
            assign w_vin     = i_valid;
            assign w_cin     = 1'b0;
        end else begin : g_body
            assign w_car_src = g_stage[k-1].g_car.r_car;
            assign w_lane_in = g_stage[k-1].w_lane;
            assign w_vin     = g_stage[k-1].w_valid;
            assign w_cin     = g_stage[k-1].w_cout;
        end

        csa_resolve_seg #(
            .IN_W (IN_W),
            .LO   (LO),
            .W    (W)
        ) u_seg (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_en),
            .i_valid (w_vin),
            .i_lane  (w_lane_in),
            .i_carry (w_car_src[W-1:0]),
            .i_cin   (w_cin),
            .o_valid (w_valid),
            .o_lane  (w_lane),
            .o_cout  (w_cout)
        );

        // Carry bits not yet consumed travel alongside, right-aligned to the next segment.
        if (k < NSEG - 1) begin : g_car
            logic [IN_W-LO-W-1:0] r_car;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_car <= '0;
                end else if (w_en) begin
                    r_car <= w_car_src[IN_W-LO-1:W];
                end
            end
        end
    end

    assign o_valid  = g_stage[NSEG-1].w_valid;
    assign o_result = {g_stage[NSEG-1].w_cout, g_stage[NSEG-1].w_lane};

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// tb/tb_csa_resolve_pipe.sv - directed and scoreboarded checks of csa_resolve_pipe
module tb_csa_resolve_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid;
    logic       i_ready;
    logic [3:0] i_sum;
    logic [3:0] i_carry;
    logic       o_ready;
    logic       o_valid;
    logic [4:0] o_result;

    logic       o_ready1;
    logic       o_valid1;
    logic [4:0] o_result1;

    logic       i_valid5;
    logic [4:0] i_sum5;
    logic [4:0] i_carry5;
    logic       o_ready5;
    logic       o_valid5;
    logic [5:0] o_result5;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int q[$];
    int n_rnd_in  = 0;
    int n_rnd_out = 0;

    always #5 clk = ~clk;

    csa_resolve_pipe #(.IN_W(4), .SEG_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_sum    (i_sum),
        .i_carry  (i_carry),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
    );

    csa_resolve_pipe #(.IN_W(4), .SEG_W(4)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready1),
        .i_sum    (i_sum),
        .i_carry  (i_carry),
        .o_valid  (o_valid1),
        .i_ready  (i_ready),
        .o_result (o_result1)
    );

    csa_resolve_pipe #(.IN_W(5), .SEG_W(2)) dut5 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid5),
        .o_ready  (o_ready5),
        .i_sum    (i_sum5),
        .i_carry  (i_carry5),
        .o_valid  (o_valid5),
        .i_ready  (i_ready),
        .o_result (o_result5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
        i_valid = v;
        i_sum   = a;
        i_carry = b;
    endtask

    task automatic drive5(input logic v, input logic [4:0] a, input logic [4:0] b);
        i_valid5 = v;
        i_sum5   = a;
        i_carry5 = b;
    endtask

    initial begin
        int exp_v;
        drive(1'b0, 4'd0, 4'd0);
        drive5(1'b0, 5'd0, 5'd0);
        i_ready = 1'b1;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_result", o_result, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_valid5", o_valid5, 0);
        rst_n = 1'b1;

        // single op: 10 + 6, latency 2 (latency 1 on the single-segment instance)
        drive(1'b1, 4'd10, 4'd6);
        cyc();
        i_valid = 1'b0;
        chk("single_lat1", o_valid, 0);
        chk("seg1_valid", o_valid1, 1);
        chk("seg1_result", o_result1, 16);
        cyc();
        chk("single_valid", o_valid, 1);
        chk("single_result", o_result, 16);
        cyc();
        chk("single_drop", o_valid, 0);

        // back-to-back max, zero, and a 3:2 compressed 7+7+7 (sum 7, carry 14)
        drive(1'b1, 4'd15, 4'd15);
        cyc();
        drive(1'b1, 4'd0, 4'd0);
        cyc();
        chk("max_valid", o_valid, 1);
        chk("max_result", o_result, 30);
        drive(1'b1, 4'd7, 4'd14);
        cyc();
        i_valid = 1'b0;
        chk("zero_valid", o_valid, 1);
        chk("zero_result", o_result, 0);
        cyc();
        chk("csa_valid", o_valid, 1);
        chk("csa_result", o_result, 21);
        cyc();
        chk("b2b_drop", o_valid, 0);

        // stall with output held
        drive(1'b1, 4'd1, 4'd1);
        cyc();
        drive(1'b1, 4'd2, 4'd2);
        cyc();
        chk("stall_first", o_result, 2);
        drive(1'b1, 4'd3, 4'd3);
        i_ready = 1'b0;
        #1;
        chk("stall_ready", o_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_valid", o_valid, 1);
            chk("stall_hold", o_result, 2);
        end
        i_ready = 1'b1;
        cyc();
        i_valid = 1'b0;
        chk("stall_out4", o_result, 4);
        cyc();
        chk("stall_out6_v", o_valid, 1);
        chk("stall_out6", o_result, 6);
        cyc();
        chk("stall_drop", o_valid, 0);

        // asynchronous reset with two tokens in flight
        drive(1'b1, 4'd5, 4'd5);
        cyc();
        drive(1'b1, 4'd6, 4'd6);
        cyc();
        i_valid = 1'b0;
        i_ready = 1'b0;
        chk("rstmid_pre", o_result, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_valid", o_valid, 0);
        chk("rstmid_result", o_result, 0);
        chk("rstmid_valid1", o_valid1, 0);
        #1 rst_n = 1'b1;
        i_ready = 1'b1;
        drive(1'b1, 4'd3, 4'd4);
        cyc();
        i_valid = 1'b0;
        chk("rstmid_empty", o_valid, 0);
        cyc();
        chk("rstmid_new_v", o_valid, 1);
        chk("rstmid_new", o_result, 7);
        cyc();
        chk("rstmid_drop", o_valid, 0);

        // odd width, three segments, carry ripples through every stage
        drive5(1'b1, 5'd31, 5'd1);
        cyc();
        chk("odd_lat1", o_valid5, 0);
        drive5(1'b1, 5'd31, 5'd31);
        cyc();
        i_valid5 = 1'b0;
        chk("odd_lat2", o_valid5, 0);
        cyc();
        chk("odd_valid", o_valid5, 1);
        chk("odd_result", o_result5, 32);
        cyc();
        chk("odd_max", o_result5, 62);
        cyc();
        chk("odd_drop", o_valid5, 0);

        // random traffic against a sum queue
        for (int n = 0; n < 1500; n++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_sum   = 4'($urandom);
            i_carry = 4'($urandom);
            #1;
            if (o_valid && i_ready) begin
                exp_v = (q.size() != 0) ? q.pop_front() : -1;
                chk("rnd_result", o_result, exp_v);
                n_rnd_out++;
            end
            if (i_valid && o_ready) begin
                q.push_back(int'(i_sum) + int'(i_carry));
                n_rnd_in++;
            end
            cyc();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1;
            if (o_valid) begin
                exp_v = (q.size() != 0) ? q.pop_front() : -1;
                chk("rnd_drain", o_result, exp_v);
                n_rnd_out++;
            end
            cyc();
        end
        chk("rnd_left", q.size(), 0);
        chk("rnd_count", n_rnd_out, n_rnd_in);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
